uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries (power of two, 2..256).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port uart_rx_re, input, 1 bit: pop request from the data-memory MMIO read of 0x1000_0000.
REQ-008 SHALL have port uart_rx_data, output, 8 bits: FIFO head byte (first-word-fall-through).
REQ-009 SHALL have port uart_rx_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port overrun, output, 1 bit: sticky, a byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err, output, 1 bit: sticky, a stop bit sampled low.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-013 SHALL generate a 16x oversample tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (100 MHz/115200 -> 54); divider counts only while FSM is not IDLE and restarts at 0 on leaving IDLE.
REQ-014 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-015 IDLE: on synchronized rx == 0, go to START.
REQ-016 START: after 8 ticks re-sample rx; if 1 (glitch) return to IDLE with no push; if 0 go to DATA, tick count cleared.
REQ-017 DATA: sample rx every 16 ticks, shift LSB-first; after the 8th sample go to STOP.
REQ-018 STOP: after 16 ticks sample rx; if 1 push byte; if 0 set frame_err, discard byte; both go to IDLE.
REQ-019 Push when FIFO full SHALL drop the new byte, keep existing contents, set overrun.
REQ-020 Pop SHALL occur on the clock edge where uart_rx_re == 1 and uart_rx_valid == 1; uart_rx_data updates to the next entry the following cycle.
REQ-021 uart_rx_re while empty SHALL be ignored; pointers and count unchanged.
REQ-022 Simultaneous push and pop SHALL both take effect, count unchanged; pop on full plus push SHALL NOT overrun.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-024 uart_rx_data SHALL be combinational from storage at the read pointer, valid whenever uart_rx_valid == 1, don't-care otherwise.
REQ-025 Latency: uart_rx_valid SHALL rise one clock after the stop-bit sample edge.

Reset
REQ-026 On rst: FSM IDLE, divider/bit counters 0, shift register 0, pointers and count 0, uart_rx_valid 0, overrun 0, frame_err 0, synchronizer 1.
REQ-027 Reset mid-frame SHALL abandon the frame; no partial byte is ever pushed; reception resumes at the next falling edge after release.
REQ-028 overrun and frame_err SHALL clear only by reset.

Structure
REQ-029 Shared package uart_defs SHALL hold FSM state encodings, OVERSAMPLE = 16, and the DIV computation function, reused by the future UART TX block.
REQ-030 Storage SHALL be a sub-module sync_fifo (width 8, depth FIFO_DEPTH, FWFT, full/empty/count); FSM, divider and synchronizer stay in uart_rx_fifo.

Verification (CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, 160 clocks/bit)
REQ-031 Frame 0xA5 at nominal rate -> uart_rx_valid=1, uart_rx_data=0xA5; pulse uart_rx_re one cycle -> valid=0, flags 0.
REQ-032 rx low for 40 clocks then high -> no push, FSM back in IDLE, valid stays 0.
REQ-033 Frame 0x3C with stop bit held low -> frame_err=1, valid=0.
REQ-034 17 frames 0x00..0x10 with no reads (depth 16) -> overrun=1; 16 pops return 0x00..0x0F in order, then valid=0.
REQ-035 uart_rx_re asserted on the same edge a push lands, FIFO holding 1 byte -> count stays 1, head advances to new byte.
REQ-036 rst asserted mid-DATA of 0x55, released, frame 0x81 sent -> only 0x81 received, flags 0.

Source files
------------

// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
// Shared UART definitions for the receive path and the future transmit block.
//   OVERSAMPLE   : oversample ticks per serial bit
//   uart_state_t : frame FSM state encoding
//   calc_div     : clocks per oversample tick, rounded to nearest
// -----------------------------------------------------------------------------
package uart_defs;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // round(clk_freq / (baud * OVERSAMPLE)); 64-bit math so large clocks cannot overflow
  function automatic int calc_div(input int clk_freq, input int baud);
    longint num;
    longint den;
    den = longint'(baud) * longint'(OVERSAMPLE);
    num = longint'(clk_freq) + den / 2;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_wr_data (ignored when full unless a pop happens too)
//   i_wr_data    : write data
//   i_pop        : advance the head (ignored when empty)
//   o_rd_data    : head entry, combinational from storage at the read pointer
//   o_full       : count == DEPTH
//   o_empty      : count == 0
//   o_count      : entries held, 0..DEPTH
// DEPTH must be a power of two so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset so it maps onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver with 16x oversampling feeding a FWFT receive FIFO.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   rx            : asynchronous serial line, idle high
//   uart_rx_re    : pop request (MMIO read strobe)
//   uart_rx_data  : FIFO head byte, valid while uart_rx_valid
//   uart_rx_valid : FIFO non-empty
//   overrun       : sticky, a received byte was dropped on a full FIFO
//   frame_err     : sticky, a stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       uart_rx_re,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  uart_state_t               r_state;
  logic                      r_sync1;
  logic                      r_sync2;
  logic [DW-1:0]             r_div_cnt;
  logic [3:0]                r_tick_cnt;
  logic [2:0]                r_bit_cnt;
  logic [7:0]                r_shift;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic                      w_rx;
  logic                      w_tick;
  logic                      w_push;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_overflow;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign w_rx = r_sync2;

  // Two-flop synchronizer, reset to the idle line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Oversample divider: held at 0 in IDLE so every frame starts phase-aligned
  assign w_tick = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (r_state == ST_IDLE || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // Push is combinational on the stop-sample edge so valid rises right after it
  assign w_push = (r_state == ST_STOP) && w_tick && (r_tick_cnt == 4'd15) && w_rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!w_rx) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              // mid start bit: high means a glitch, abandon quietly
              r_tick_cnt <= '0;
              r_state    <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;   // wraps to 0 after each sample
            if (r_tick_cnt == 4'd15) begin
              r_shift   <= {w_rx, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              if (!w_rx) r_frame_err <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A byte is lost only when full and no pop frees a slot on the same edge
  assign w_overflow = w_push & w_full & ~(uart_rx_re & ~w_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_overflow) begin
      r_overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (r_shift),
    .i_pop     (uart_rx_re),
    .o_rd_data (uart_rx_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign uart_rx_valid = (w_count != '0);
  assign overrun       = r_overrun;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed frames against a queue-based model of the receiver. The model
// knows only frame timing (2-flop sync, 8 ticks to mid start bit, 16 ticks per
// later bit) and FIFO rules; a negedge process compares it every cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int BIT_CLKS = 16 * DIV;
  // edge of stop-bit sample relative to first edge that sees the start bit
  localparam int PUSH_LAT = 2 + DIV * (8 + 16 * 9);

  logic       clk;
  logic       rst;
  logic       rx;
  logic       uart_rx_re;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       overrun;
  logic       frame_err;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .uart_rx_re    (uart_rx_re),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    bit         ok;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_ferr;
  int         cyc;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: advances on every rising edge using pre-edge inputs
  initial begin
    bit pop;
    cyc = 0;
    m_ovr = 0;
    m_ferr = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        ev_q.delete();
        m_ovr = 0;
        m_ferr = 0;
      end else begin
        pop = uart_rx_re && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (ev_q.size() > 0 && ev_q[0].at_edge == cyc) begin
          if (ev_q[0].ok) begin
            if (mq.size() == DEPTH) m_ovr = 1;
            else mq.push_back(ev_q[0].data);
          end else begin
            m_ferr = 1;
          end
          void'(ev_q.pop_front());
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cyc_valid", 32'(uart_rx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("cyc_data", 32'(uart_rx_data), 32'(mq[0]));
        check("cyc_overrun", 32'(overrun), 32'(m_ovr));
        check("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
      end
    end
  end

  // Drives one 8N1 frame; optionally pops on exactly the edge its byte lands
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pop_at_push);
    ev_t e;
    e.at_edge = cyc + 1 + PUSH_LAT;
    e.ok      = stop;
    e.data    = d;
    ev_q.push_back(e);
    $display("frame tx 0x%02h stop=%0d pop_at_push=%0d", d, stop, pop_at_push);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      rx = 1'b0;
      else if (j == 9) rx = stop;
      else             rx = d[j-1];
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (pop_at_push) uart_rx_re = (cyc + 1 == e.at_edge);
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
    if (pop_at_push) uart_rx_re = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    $display("pop head 0x%02h valid=%0d", uart_rx_data, uart_rx_valid);
    uart_rx_re = 1'b1;
    @(posedge clk);
    #1;
    uart_rx_re = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    rx = 1'b1;
    uart_rx_re = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_valid", 32'(uart_rx_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // nominal frame then a single pop
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid", 32'(uart_rx_valid), 32'd1);
    check("a5_data", 32'(uart_rx_data), 32'hA5);
    pop_one();
    check("a5_popped_valid", 32'(uart_rx_valid), 32'd0);
    check("a5_overrun", 32'(overrun), 32'd0);
    check("a5_frame_err", 32'(frame_err), 32'd0);

    // 40-clock glitch on the line
    $display("glitch 40 clocks low");
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("glitch_valid", 32'(uart_rx_valid), 32'd0);

    // stop bit held low
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_flag", 32'(frame_err), 32'd1);
    check("ferr_valid", 32'(uart_rx_valid), 32'd0);

    // push and pop on the same edge with one byte held
    send_frame(8'h11, 1'b1, 1'b0);
    check("hold1_data", 32'(uart_rx_data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b1);
    check("simul_valid", 32'(uart_rx_valid), 32'd1);
    check("simul_data", 32'(uart_rx_data), 32'h22);
    pop_one();
    check("simul_empty", 32'(uart_rx_valid), 32'd0);

    // fill past depth, then drain
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(uart_rx_valid), 32'd1);
      check("drain_data", 32'(uart_rx_data), 32'(i));
      pop_one();
    end
    check("drain_empty", 32'(uart_rx_valid), 32'd0);

    // reset mid-DATA of 0x55, then a clean 0x81
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (600) @(posedge clk);
        #1;
        $display("reset asserted mid-frame");
        rst = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, 1'b0);
    check("rst_valid", 32'(uart_rx_valid), 32'd1);
    check("rst_data", 32'(uart_rx_data), 32'h81);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    pop_one();
    check("rst_empty", 32'(uart_rx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
